frame_scan_ctl: RTL and testbench
=================================

Name: frame_scan_ctl

Overview:
- Display-side scheduler for the 8-layer LED cube.
- Owns a ping-pong pair of layer RAM banks: the SPI write path fills the bank not selected by bank_sel_out, while this block scans the selected bank.
- Per frame: reads pixel addresses 0..63 from all 8 layer RAMs in parallel, hands each 8-layer pixel word to the 8 lockstep NeoPixel encoders over a valid/ready handshake, then holds the WS2812 latch gap.
- Bank swaps happen only at frame boundaries, so a displayed frame is never torn.

Parameters:
- ADDR_W, 6, pixel address width; pixels per layer = 2**ADDR_W; last address = all-ones.
- GAP_CYCLES, 4000, clk_in cycles of latch gap after the last pixel (80 us at 50 MHz); minimum 1.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- wr_done_in  input  1  single-cycle pulse from write path: write bank holds a complete frame; requests a swap.
- refresh_in  input  1  single-cycle pulse: redisplay current bank without swap.
- bank_sel_out  output  1  bank being scanned; write path uses ~bank_sel_out.
- rd_en_out  output  1  RAM read strobe, all 8 layers.
- rd_addr_out  output  ADDR_W  RAM read address.
- rd_data_in  input  192  8 x 24-bit GRB; layer n occupies [24n+23:24n]; valid exactly 1 cycle after rd_en_out.
- pix_valid_out  output  1  pixel word available to encoders.
- pix_data_out  output  192  pixel word, layout as rd_data_in.
- pix_ready_in  input  1  encoders accept word (transfer = valid & ready at a rising edge).
- busy_out  output  1  high in any state other than IDLE.
- frame_done_out  output  1  single-cycle pulse at end of latch gap.

Behaviour:
- Reset values: state IDLE; bank_sel_out 0; rd_en_out 0; rd_addr_out 0; pix_valid_out 0; pix_data_out 0; busy_out 0; frame_done_out 0; swap_pend 0; gap counter 0.
- Reset may assert in any state and returns everything to the reset values immediately. Any in-flight pixel is dropped and swap_pend is cleared.
- swap_pend:
  - set by wr_done_in in any state;
  - cleared only when a swap is consumed in IDLE;
  - wr_done_in in the same cycle as consumption leaves it set.
- States and transitions:
  - IDLE:
    - if swap_pend: toggle bank_sel_out, clear swap_pend, go to READ;
    - else if refresh_in: go to READ with no toggle;
    - if both swap_pend and refresh_in are present, exactly one frame starts, with swap.
    - rd_addr_out is 0 on entry to READ.
  - READ: 1 cycle; rd_en_out=1 with rd_addr_out current; go to CAPT.
  - CAPT: 1 cycle; register rd_data_in into pix_data_out; set pix_valid_out; go to SEND.
  - SEND:
    - pix_valid_out held high and pix_data_out held stable until transfer; ready without valid is ignored.
    - On transfer with rd_addr_out != last: pix_valid_out 0, rd_addr_out+1, go to READ.
    - On transfer with rd_addr_out == last: pix_valid_out 0, rd_addr_out wraps to 0, load gap counter, go to GAP.
  - GAP: counts exactly GAP_CYCLES cycles. On the final cycle, frame_done_out=1 for one cycle and the state returns to IDLE.
- rd_en_out is a registered output, high only in READ. busy_out is registered and equals (state != IDLE).
- Latency:
  - Start condition sampled in IDLE at edge t: READ in cycle t+1, CAPT in t+2, pix_valid_out high from t+3.
  - Minimum per pixel is 3 cycles if ready is held high.
  - Frame length = 64 x (3 + ready stall) + GAP_CYCLES + 1 IDLE cycle.
- refresh_in outside IDLE is ignored (not latched). wr_done_in during a frame is deferred to the next IDLE.
- Back-to-back: a pending swap in IDLE starts the next frame one cycle after frame_done_out.

Test Plan:
- Reset, then wr_done_in pulse (GAP_CYCLES=8, ready tied 1) -> bank_sel_out 0->1 on the next edge; rd_addr_out sequence 0..63; 64 transfers, each pix_data_out equal to the RAM model contents; GAP of 8 cycles; one frame_done_out pulse; return to IDLE.
- Backpressure: pix_ready_in low for 5 cycles at pixel 10 -> pix_valid_out stays 1 and pix_data_out is unchanged throughout; no rd_en_out pulse until the transfer; pixel 11 read follows.
- wr_done_in at pixel 30 of a frame -> no bank change mid-frame; after frame_done_out, bank toggles and a second frame starts with addr 0.
- refresh_in alone in IDLE -> frame scans without toggle. refresh_in during SEND -> ignored, no extra frame. refresh_in and wr_done_in in the same IDLE cycle -> one frame, bank toggled.
- Reset asserted in SEND at pixel 40 -> all outputs 0 asynchronously, bank_sel_out 0, swap_pend cleared; after release, no frame starts without a new request.
- rd_data_in with layer n = 24'h0n0n0n -> pix_data_out slice [24n+23:24n] equals that value for all n.

Source files
------------

// File: rtl/frame_scan_ctl.sv
// Frame scheduler for the 8-layer LED cube: scans one ping-pong RAM bank pixel by pixel,
// hands pixel words to the encoders over valid/ready, then holds the WS2812 latch gap.
module frame_scan_ctl #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned GAP_CYCLES = 4000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              wr_done_in,
  input  logic              refresh_in,
  output logic              bank_sel_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [191:0]      rd_data_in,
  output logic              pix_valid_out,
  output logic [191:0]      pix_data_out,
  input  logic              pix_ready_in,
  output logic              busy_out,
  output logic              frame_done_out
);

  localparam int unsigned     GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad  = GapW'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [2:0] {StIdle, StRead, StCapt, StSend, StGap} state_e;

  state_e          state_q;
  logic            swap_pend_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            start_swap;

  // A wr_done arriving in the same IDLE cycle is honoured immediately, so a
  // simultaneous refresh still yields a single, swapped frame.
  assign start_swap = swap_pend_q | wr_done_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= StIdle;
      swap_pend_q    <= 1'b0;
      gap_cnt_q      <= '0;
      bank_sel_out   <= 1'b0;
      rd_en_out      <= 1'b0;
      rd_addr_out    <= '0;
      pix_valid_out  <= 1'b0;
      pix_data_out   <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      if (wr_done_in) begin
        swap_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_swap) begin
            bank_sel_out <= ~bank_sel_out;
            // Only a fresh wr_done on top of an already pending one survives consumption.
            swap_pend_q  <= swap_pend_q & wr_done_in;
            state_q      <= StRead;
            rd_en_out    <= 1'b1;
            busy_out     <= 1'b1;
          end else if (refresh_in) begin
            state_q   <= StRead;
            rd_en_out <= 1'b1;
            busy_out  <= 1'b1;
          end
        end
        StRead: begin
          rd_en_out <= 1'b0;
          state_q   <= StCapt;
        end
        StCapt: begin
          pix_data_out  <= rd_data_in;
          pix_valid_out <= 1'b1;
          state_q       <= StSend;
        end
        StSend: begin
          if (pix_ready_in) begin
            pix_valid_out <= 1'b0;
            if (rd_addr_out == LastAddr) begin
              rd_addr_out    <= '0;
              gap_cnt_q      <= GapLoad;
              frame_done_out <= (GAP_CYCLES == 1);
              state_q        <= StGap;
            end else begin
              rd_addr_out <= rd_addr_out + ADDR_W'(1);
              rd_en_out   <= 1'b1;
              state_q     <= StRead;
            end
          end
        end
        StGap: begin
          // frame_done is registered, so it is raised while the counter steps from 1 to 0.
          if (gap_cnt_q == '0) begin
            state_q  <= StIdle;
            busy_out <= 1'b0;
          end else begin
            gap_cnt_q      <= gap_cnt_q - GapW'(1);
            frame_done_out <= (gap_cnt_q == GapW'(1));
          end
        end
        default: begin
          state_q       <= StIdle;
          rd_en_out     <= 1'b0;
          pix_valid_out <= 1'b0;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scan_ctl.sv
// Directed bench for frame_scan_ctl: RAM model, scoreboard of expected pixel words,
// negedge monitor for transfers, stalls, read addresses and latch-gap length.
module tb_frame_scan_ctl;

  localparam int unsigned AW  = 6;
  localparam int unsigned GAP = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          wr_done_in = 1'b0;
  logic          refresh_in = 1'b0;
  logic          pix_ready_in = 1'b1;
  logic [191:0]  rd_data_in = '0;
  logic          bank_sel_out, rd_en_out, pix_valid_out, busy_out, frame_done_out;
  logic [AW-1:0] rd_addr_out;
  logic [191:0]  pix_data_out;

  frame_scan_ctl #(.ADDR_W(AW), .GAP_CYCLES(GAP)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .wr_done_in     (wr_done_in),
    .refresh_in     (refresh_in),
    .bank_sel_out   (bank_sel_out),
    .rd_en_out      (rd_en_out),
    .rd_addr_out    (rd_addr_out),
    .rd_data_in     (rd_data_in),
    .pix_valid_out  (pix_valid_out),
    .pix_data_out   (pix_data_out),
    .pix_ready_in   (pix_ready_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0;
  int cyc = 0, last_xfer_cyc = 0, xfer_cnt = 0, done_cnt = 0, stall_cnt = 0;
  bit pat_mode = 1'b0;
  logic [191:0]  q_data[$];
  logic [AW-1:0] q_addr[$];

  function automatic logic [191:0] ram_word(input logic bank, input logic [AW-1:0] a,
                                            input bit pat);
    logic [191:0] w;
    logic [3:0]   nn;
    w = '0;
    for (int n = 0; n < 8; n++) begin
      nn = 4'(n);
      if (pat) w[24*n +: 24] = {4'h0, nn, 4'h0, nn, 4'h0, nn};
      else     w[24*n +: 24] = {nn, 3'b000, bank, 2'b00, a, 8'hA5 ^ {2'b00, a}};
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous RAM model: data valid one cycle after rd_en.
  always @(posedge clk_in) begin
    if (rd_en_out) rd_data_in <= ram_word(bank_sel_out, rd_addr_out, pat_mode);
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic [AW-1:0] exp_rd_addr;
    logic [191:0]  hold_data;
    logic [191:0]  e_data;
    logic [AW-1:0] e_addr;
    bit            prev_stall;
    exp_rd_addr = '0;
    hold_data   = '0;
    prev_stall  = 1'b0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        exp_rd_addr = '0;
        prev_stall  = 1'b0;
      end else begin
        if (rd_en_out) begin
          chk("rd_addr_seq", 192'(rd_addr_out), 192'(exp_rd_addr));
          exp_rd_addr++;
        end
        if (prev_stall) begin
          chk("stall_valid_held", 192'(pix_valid_out), 192'(1));
          chk("stall_data_stable", pix_data_out, hold_data);
        end
        if (pix_valid_out && !pix_ready_in) begin
          stall_cnt++;
          chk("stall_no_rd_en", 192'(rd_en_out), 192'(0));
          prev_stall = 1'b1;
          hold_data  = pix_data_out;
        end else begin
          prev_stall = 1'b0;
        end
        if (pix_valid_out && pix_ready_in) begin
          chk("xfer_expected", 192'(q_data.size() != 0), 192'(1));
          if (q_data.size() != 0) begin
            e_data = q_data.pop_front();
            e_addr = q_addr.pop_front();
            chk("xfer_data", pix_data_out, e_data);
            chk("xfer_addr", 192'(rd_addr_out), 192'(e_addr));
          end
          if (rd_addr_out == '1) last_xfer_cyc = cyc;
          xfer_cnt++;
        end
        if (frame_done_out) begin
          chk("gap_len", 192'(cyc - last_xfer_cyc), 192'(GAP));
          done_cnt++;
        end
      end
    end
  end

  task automatic push_frame(input logic bank, input bit pat);
    for (int a = 0; a < 64; a++) begin
      q_data.push_back(ram_word(bank, AW'(a), pat));
      q_addr.push_back(AW'(a));
    end
  endtask

  task automatic pulse(input bit wr, input bit rf);
    @(posedge clk_in);
    #1 wr_done_in = wr; refresh_in = rf;
    @(posedge clk_in);
    #1 wr_done_in = 1'b0; refresh_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (frame_done_out) found = 1'b1;
    end
    chk("frame_done_seen", 192'(found), 192'(1));
    if (found) begin
      @(negedge clk_in);
      chk("frame_done_width", 192'(frame_done_out), 192'(0));
      chk("idle_after_gap", 192'(busy_out), 192'(0));
    end
  endtask

  task automatic wait_rd(input logic [AW-1:0] a, input bit want_valid, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (rd_addr_out == a && (want_valid ? pix_valid_out : rd_en_out)) found = 1'b1;
    end
    chk("addr_reached", 192'(found), 192'(1));
  endtask

  task automatic check_quiet(input string tag, input int n);
    bit any_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (busy_out) any_busy = 1'b1;
    end
    chk(tag, 192'(any_busy), 192'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bank"},  192'(bank_sel_out),   192'(0));
    chk({tag, "_rd_en"}, 192'(rd_en_out),      192'(0));
    chk({tag, "_addr"},  192'(rd_addr_out),    192'(0));
    chk({tag, "_valid"}, 192'(pix_valid_out),  192'(0));
    chk({tag, "_data"},  pix_data_out,         192'(0));
    chk({tag, "_busy"},  192'(busy_out),       192'(0));
    chk({tag, "_done"},  192'(frame_done_out), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] lay;
    // Reset state
    repeat (2) @(posedge clk_in);
    #1 check_reset_outputs("reset");
    @(negedge clk_in) rst_n_in = 1'b1;
    check_quiet("no_start_after_reset", 5);

    // Swap frame with ready tied high
    push_frame(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("swap_bank", 192'(bank_sel_out), 192'(1));
    chk("swap_busy", 192'(busy_out), 192'(1));
    chk("swap_rd_en", 192'(rd_en_out), 192'(1));
    wait_done(400);
    chk("frame1_xfers", 192'(xfer_cnt), 192'(64));
    chk("frame1_dones", 192'(done_cnt), 192'(1));
    chk("frame1_queue", 192'(q_data.size()), 192'(0));

    // Refresh without swap, backpressure at pixel 10, refresh mid-frame ignored
    push_frame(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("refresh_bank", 192'(bank_sel_out), 192'(1));
    chk("refresh_busy", 192'(busy_out), 192'(1));
    wait_rd(AW'(10), 1'b0, 100);
    @(posedge clk_in);
    #1 pix_ready_in = 1'b0;
    stall_cnt = 0;
    repeat (6) @(posedge clk_in);
    #1 pix_ready_in = 1'b1;
    chk("stall_cycles", 192'(stall_cnt), 192'(5));
    wait_rd(AW'(20), 1'b1, 100);
    pulse(1'b0, 1'b1);
    wait_done(400);
    check_quiet("refresh_in_frame_ignored", 20);
    chk("frame2_queue", 192'(q_data.size()), 192'(0));

    // Swap request mid-frame is deferred to the frame boundary
    push_frame(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_rd(AW'(30), 1'b0, 200);
    pulse(1'b1, 1'b0);
    push_frame(1'b0, 1'b0);
    wait_rd(AW'(50), 1'b0, 200);
    chk("no_midframe_swap", 192'(bank_sel_out), 192'(1));
    wait_done(400);
    @(negedge clk_in);
    chk("deferred_swap_bank", 192'(bank_sel_out), 192'(0));
    chk("deferred_swap_rd_en", 192'(rd_en_out), 192'(1));
    chk("deferred_swap_addr", 192'(rd_addr_out), 192'(0));
    wait_done(400);
    check_quiet("no_third_frame", 20);
    chk("frame4_queue", 192'(q_data.size()), 192'(0));

    // Refresh and wr_done together: one swapped frame
    push_frame(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    chk("both_bank", 192'(bank_sel_out), 192'(1));
    wait_done(400);
    check_quiet("both_single_frame", 20);
    chk("frame5_queue", 192'(q_data.size()), 192'(0));

    // Asynchronous reset in SEND with a swap pending
    push_frame(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_rd(AW'(20), 1'b0, 200);
    pulse(1'b1, 1'b0);
    wait_rd(AW'(40), 1'b1, 200);
    #1 rst_n_in = 1'b0;
    #1 check_reset_outputs("async_rst");
    q_data.delete();
    q_addr.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    check_quiet("pend_cleared_by_reset", 300);
    chk("bank_after_reset", 192'(bank_sel_out), 192'(0));

    // Per-layer slice placement
    pat_mode = 1'b1;
    push_frame(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    wait_rd(AW'(5), 1'b1, 100);
    for (int n = 0; n < 8; n++) begin
      lay = {4'h0, 4'(n), 4'h0, 4'(n), 4'h0, 4'(n)};
      chk("layer_slice", 192'(pix_data_out[24*n +: 24]), 192'(lay));
    end
    wait_done(400);
    chk("pattern_queue", 192'(q_data.size()), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
